// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select, with optional burst lock and a
// registered valid/ready output slot that captures the selected mux word.
module mux_rr_arbiter #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned BURST_LEN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   output logic [3:0]       grant,
   output logic [1:0]       sel,
   input  logic [WIDTH-1:0] mux_y,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_src,
   input  logic             out_ready
);

   localparam int unsigned CW = (BURST_LEN < 1) ? 1 : $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_t;

   slot_t            slot_q, slot_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       cur_q, cur_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       src_q, src_d;

   logic [1:0] rr_win;
   logic       rr_hit;
   logic [1:0] idx;
   logic [1:0] winner;
   logic       in_burst;
   logic       load;
   logic       fire;

   // Round-robin scan: first requester starting at ptr, wrapping mod 4.
   always_comb begin
      rr_win = ptr_q;
      rr_hit = 1'b0;
      idx    = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!rr_hit && req[idx]) begin
            rr_win = idx;
            rr_hit = 1'b1;
         end
      end
   end

   always_comb begin
      in_burst = (cnt_q != '0) && (cnt_q < BURST_MAX) && req[cur_q];
      winner   = in_burst ? cur_q : rr_win;
      load     = (slot_q == EMPTY) || out_ready;
      fire     = load && (req != '0) && !rst;
      grant    = fire ? (4'b0001 << winner) : '0;
      if (rst)
         sel = '0;
      else if (fire)
         sel = winner;
      else
         sel = ptr_q;
   end

   always_comb begin
      slot_d = slot_q;
      ptr_d  = ptr_q;
      cur_d  = cur_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      src_d  = src_q;
      if (fire) begin
         slot_d = FULL;
         data_d = mux_y;
         src_d  = winner;
         ptr_d  = winner + 2'd1;
         if ((winner == cur_q) && (cnt_q != '0) && (cnt_q < BURST_MAX)) begin
            cnt_d = cnt_q + CW'(1);
         end else begin
            cur_d = winner;
            cnt_d = CW'(1);
         end
      end else if ((slot_q == FULL) && out_ready) begin
         slot_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= EMPTY;
         ptr_q  <= '0;
         cur_q  <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         src_q  <= '0;
      end else begin
         slot_q <= slot_d;
         ptr_q  <= ptr_d;
         cur_q  <= cur_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
         src_q  <= src_d;
      end
   end

   assign out_valid = (slot_q == FULL);
   assign out_data  = data_q;
   assign out_src   = src_q;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(grant));
   a_grant_in_req : assert property (@(posedge clk) disable iff (rst)
      (grant & ~req) == 4'b0000);
   a_hold_stable : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_src)));

endmodule
